apb_master_arb: RTL and testbench
=================================

# apb_master_arb

Two-requester APB master that arbitrates round-robin between two local requesters and sequences one APB transfer at a time (SETUP, ACCESS, optional read-capture) onto a shared bus of APB slaves (e.g. the byte-strobed memory slave with PREADY = PSEL && PENABLE and registered PRDATA). It returns read data, or a timeout error, to the granted requester as a single-cycle response pulse. It sits between CPU/DMA-side request ports and the APB slave address space.

## Interface
- ADDWIDTH, 8, APB address width
- DATAWIDTH, 32, APB data width (multiple of 8)
- TIMEOUT, 16, max ACCESS cycles before abort; 0 disables timeout
- RD_LAG, 1, 1 = slave PRDATA valid one cycle after the completing ACCESS edge; 0 = valid in the completing ACCESS cycle
- PCLK  in  1  clock, all logic on rising edge
- PRESETn  in  1  reset; asynchronous, active-low
- req_valid  in  2  per-requester request; held with fields until req_ready
- req_write  in  2  per-requester direction, 1 = write
- req_addr  in  2*ADDWIDTH  requester i at [i*ADDWIDTH +: ADDWIDTH]
- req_wdata  in  2*DATAWIDTH  requester i at [i*DATAWIDTH +: DATAWIDTH]
- req_strb  in  2*(DATAWIDTH/8)  write byte strobes per requester
- req_ready  out  2  combinational accept, one-hot or zero
- rsp_valid  out  2  registered one-cycle response pulse, one-hot or zero
- rsp_rdata  out  DATAWIDTH  read data, valid with rsp_valid; 0 for writes and errors
- rsp_err  out  1  timeout flag, valid with rsp_valid
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDWIDTH; PWDATA  out  DATAWIDTH; PSTRB  out  DATAWIDTH/8
- PREADY  in  1; PRDATA  in  DATAWIDTH

## Operation
- FSM states: IDLE, SETUP, ACCESS, CAPTURE. Reset: IDLE, last-grant pointer = 1 (requester 0 wins first), all registered outputs 0.
- IDLE: if any req_valid, grant = sole requester, or on contention the one not granted last. req_ready[grant]=1 this cycle only; at the edge latch write/addr/wdata/strb, update pointer, go SETUP. req_ready is 0 in every other state.
- SETUP (1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB = latched values; go ACCESS; clear timeout counter.
- ACCESS: PSEL=1, PENABLE=1, address/data/control held stable. Counter increments each ACCESS cycle without PREADY.
  - PREADY=1: write or RD_LAG=0 → go IDLE, next cycle rsp_valid[grant]=1, rsp_err=0, rsp_rdata = PRDATA sampled at that edge for reads (0 for writes). Read with RD_LAG=1 → go CAPTURE.
  - PREADY=0 in the TIMEOUT-th ACCESS cycle (TIMEOUT≠0) → go IDLE, next cycle rsp_valid[grant]=1, rsp_err=1, rsp_rdata=0. PREADY=1 in that same cycle takes priority (no error).
- CAPTURE: PSEL=0, PENABLE=0; sample PRDATA at edge; go IDLE; next cycle read response with rsp_err=0.
- PSEL/PENABLE 0 in IDLE and CAPTURE; PADDR/PWDATA/PSTRB/PWRITE hold last values outside transfers, 0 after reset.
- One outstanding transfer; no pipelining. Requester dropping req_valid before req_ready is allowed (no transfer).
- Counter width clog2(TIMEOUT+1); saturation impossible since abort occurs at TIMEOUT.
- PRESETn low at any time (mid-transfer included): immediately IDLE, PSEL/PENABLE/req_ready/rsp_valid/rsp_err = 0, rsp_rdata = 0, pointer = 1; aborted transfer gets no response.

## Timing
- Accept cycle N (IDLE). SETUP N+1. ACCESS from N+2.
- Zero-wait write: rsp_valid at N+3, IDLE at N+3, next accept at N+3 earliest.
- Zero-wait read, RD_LAG=1: CAPTURE N+3, rsp_valid N+4. RD_LAG=0: rsp_valid N+3.
- Each slave wait state adds 1 cycle. Timeout: last ACCESS cycle N+1+TIMEOUT, rsp_valid/rsp_err at N+2+TIMEOUT.
- Outputs registered except req_ready (combinational from state, pointer, req_valid).

## Test plan
- Reset then req 0 write addr 0x10 data 0xA5A5_1234 strb 0xF, slave PREADY=PSEL&&PENABLE -> req_ready[0] cycle 0, SETUP 1, ACCESS 2, rsp_valid[0]=1 rsp_err=0 rsp_rdata=0 cycle 3.
- Then req 1 read 0x10, RD_LAG=1, registered-PRDATA slave -> PSEL low in CAPTURE, rsp_valid[1]=1 rsp_rdata=0xA5A5_1234 four cycles after accept.
- Both req_valid held high for 4 transfers -> grants 0,1,0,1 after reset; each response routed to the matching rsp_valid bit.
- Slave with 3 wait states, TIMEOUT=16 -> ACCESS lasts 4 cycles, PADDR/PWDATA stable throughout, rsp_err=0.
- PREADY stuck 0, TIMEOUT=4 -> 4 ACCESS cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0; next request serviced normally.
- PRESETn pulsed low during ACCESS -> PSEL/PENABLE 0 asynchronously, no rsp_valid, next request after release granted to requester 0.

Source files
------------

// File: rtl/apb_master_arb.sv
// Two-requester round-robin APB master: one transfer at a time through SETUP/ACCESS,
// with an optional capture cycle for slaves that register PRDATA, and an ACCESS timeout.
module apb_master_arb #(
   parameter int ADDWIDTH  = 8,
   parameter int DATAWIDTH = 32,
   parameter int TIMEOUT   = 16,
   parameter int RD_LAG    = 1
) (
   input  logic                       PCLK,
   input  logic                       PRESETn,
   input  logic [1:0]                 req_valid,
   input  logic [1:0]                 req_write,
   input  logic [2*ADDWIDTH-1:0]      req_addr,
   input  logic [2*DATAWIDTH-1:0]     req_wdata,
   input  logic [2*(DATAWIDTH/8)-1:0] req_strb,
   output logic [1:0]                 req_ready,
   output logic [1:0]                 rsp_valid,
   output logic [DATAWIDTH-1:0]       rsp_rdata,
   output logic                       rsp_err,
   output logic                       PSEL,
   output logic                       PENABLE,
   output logic                       PWRITE,
   output logic [ADDWIDTH-1:0]        PADDR,
   output logic [DATAWIDTH-1:0]       PWDATA,
   output logic [DATAWIDTH/8-1:0]     PSTRB,
   input  logic                       PREADY,
   input  logic [DATAWIDTH-1:0]       PRDATA
);
   // state   | meaning
   // IDLE    | no transfer; arbitrate and accept a request
   // SETUP   | APB setup phase (PSEL=1, PENABLE=0)
   // ACCESS  | APB access phase, waiting on PREADY or timeout
   // CAPTURE | bus released; sample lagging PRDATA

   localparam int SW = DATAWIDTH / 8;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, CAPTURE} state_t;

   state_t                 state_q, state_d;
   logic                   last_q, last_d;
   logic                   gnt_q, gnt_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   psel_q, psel_d;
   logic                   penable_q, penable_d;
   logic                   pwrite_q, pwrite_d;
   logic [ADDWIDTH-1:0]    paddr_q, paddr_d;
   logic [DATAWIDTH-1:0]   pwdata_q, pwdata_d;
   logic [SW-1:0]          pstrb_q, pstrb_d;
   logic [1:0]             rsp_valid_q, rsp_valid_d;
   logic                   rsp_err_q, rsp_err_d;
   logic [DATAWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                   gnt_sel;
   logic                   timeout_hit;

   // Requester 1 wins when alone, or on contention when requester 0 went last.
   assign gnt_sel     = req_valid[1] & (~req_valid[0] | ~last_q);
   assign req_ready   = (state_q == IDLE && |req_valid) ? (2'b01 << gnt_sel) : 2'b00;
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      gnt_d       = gnt_q;
      cnt_d       = cnt_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pstrb_d     = pstrb_q;
      rsp_valid_d = 2'b00;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               gnt_d    = gnt_sel;
               last_d   = gnt_sel;
               pwrite_d = req_write[gnt_sel];
               paddr_d  = gnt_sel ? req_addr[2*ADDWIDTH-1:ADDWIDTH] : req_addr[ADDWIDTH-1:0];
               pwdata_d = gnt_sel ? req_wdata[2*DATAWIDTH-1:DATAWIDTH] : req_wdata[DATAWIDTH-1:0];
               pstrb_d  = gnt_sel ? req_strb[2*SW-1:SW] : req_strb[SW-1:0];
               state_d  = SETUP;
            end
         end
         SETUP: begin
            cnt_d   = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (PREADY) begin
               if (pwrite_q || RD_LAG == 0) begin
                  state_d     = IDLE;
                  rsp_valid_d = 2'b01 << gnt_q;
                  rsp_rdata_d = pwrite_q ? '0 : PRDATA;
               end else begin
                  state_d = CAPTURE;
               end
            end else if (timeout_hit) begin
               state_d     = IDLE;
               rsp_valid_d = 2'b01 << gnt_q;
               rsp_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         CAPTURE: begin
            state_d     = IDLE;
            rsp_valid_d = 2'b01 << gnt_q;
            rsp_rdata_d = PRDATA;
         end
         default: state_d = IDLE;
      endcase
      psel_d    = (state_d == SETUP) || (state_d == ACCESS);
      penable_d = (state_d == ACCESS);
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         gnt_q       <= 1'b0;
         cnt_q       <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         rsp_valid_q <= 2'b00;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         gnt_q       <= gnt_d;
         cnt_q       <= cnt_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pstrb_q     <= pstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign PSTRB     = pstrb_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb against a byte-strobed memory slave with
// registered PRDATA and programmable wait states.
module tb_apb_master_arb;
   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
   logic [15:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_strb;
   logic [31:0] rsp_rdata, PWDATA, PRDATA;
   logic        rsp_err, PSEL, PENABLE, PWRITE, PREADY;
   logic [7:0]  PADDR;
   logic [3:0]  PSTRB;

   int          n_vec = 0;
   int          n_err = 0;
   int          nwait = 0;
   int          wc = 0;
   logic        stuck = 1'b0;
   logic [31:0] mem [0:255];

   // TIMEOUT=4 so the stuck-slave abort and the PREADY-in-last-cycle case are both short.
   apb_master_arb #(.ADDWIDTH(8), .DATAWIDTH(32), .TIMEOUT(4), .RD_LAG(1)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_strb(req_strb), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA)
   );

   always #5 PCLK = ~PCLK;

   assign PREADY = PSEL && PENABLE && !stuck && (wc == nwait);

   always @(posedge PCLK) begin
      if (PSEL && PENABLE && !PREADY) wc <= wc + 1;
      else                            wc <= 0;
      if (PSEL && PENABLE && PREADY) begin
         if (PWRITE) begin
            for (int b = 0; b < 4; b++)
               if (PSTRB[b]) mem[PADDR][b*8 +: 8] <= PWDATA[b*8 +: 8];
         end else begin
            PRDATA <= mem[PADDR];
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic xfer(input string tag, input logic [1:0] vld, input logic g, input logic wr,
                       input logic [7:0] addr, input logic [31:0] wd, input logic [3:0] st,
                       input int nw, input logic stk, input int exp_lat, input int exp_acc,
                       input logic exp_err, input logic [31:0] exp_rd);
      int   lat;
      int   acc;
      logic seen;
      logic [1:0] eg;
      eg    = 2'b01 << g;
      nwait = nw;
      stuck = stk;
      if (g) begin
         req_write[1] = wr; req_addr[15:8] = addr; req_wdata[63:32] = wd; req_strb[7:4] = st;
      end else begin
         req_write[0] = wr; req_addr[7:0] = addr; req_wdata[31:0] = wd; req_strb[3:0] = st;
      end
      req_valid = vld;
      #1;
      chk({tag, "_ready"}, req_ready, eg);
      lat  = 0;
      acc  = 0;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge PCLK); #1;
         lat++;
         if (lat == 1) chk({tag, "_setup"}, {PSEL, PENABLE, PADDR, PWRITE, req_ready}, {2'b10, addr, wr, 2'b00});
         if (PSEL && PENABLE) begin
            acc++;
            chk({tag, "_stable"}, {PADDR, PWDATA, PSTRB, PWRITE}, {addr, wd, st, wr});
         end
         if (rsp_valid != 2'b00) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, "_seen"}, seen, 1'b1);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_acc"}, acc, exp_acc);
      chk({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE}, {eg, exp_err, exp_rd, 2'b00});
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      PRDATA    = 32'h0;
      PRESETn   = 1'b0;
      req_valid = 2'b00;
      req_write = 2'b00;
      req_addr  = '0;
      req_wdata = '0;
      req_strb  = '0;
      repeat (2) @(posedge PCLK);
      #1;
      chk("rst_ctrl", {PSEL, PENABLE, req_ready, rsp_valid, rsp_err}, 0);
      chk("rst_data", {PADDR, PWDATA, PSTRB, PWRITE, rsp_rdata}, 0);
      PRESETn = 1'b1;
      @(posedge PCLK); #1;
      chk("idle_ctrl", {PSEL, PENABLE, rsp_valid}, 0);

      xfer("wr0",   2'b01, 1'b0, 1'b1, 8'h10, 32'hA5A5_1234, 4'hF, 0, 1'b0, 3, 1, 1'b0, 32'h0);
      xfer("rd1",   2'b10, 1'b1, 1'b0, 8'h10, 32'h0,         4'h0, 0, 1'b0, 4, 1, 1'b0, 32'hA5A5_1234);
      // Three wait states end in the 4th ACCESS cycle: PREADY beats the timeout there.
      xfer("wait3", 2'b01, 1'b0, 1'b1, 8'h30, 32'hDEAD_BEEF, 4'hF, 3, 1'b0, 6, 4, 1'b0, 32'h0);
      xfer("rdw2",  2'b10, 1'b1, 1'b0, 8'h30, 32'h0,         4'h0, 2, 1'b0, 6, 3, 1'b0, 32'hDEAD_BEEF);
      xfer("tmo",   2'b01, 1'b0, 1'b0, 8'h10, 32'h0,         4'h0, 0, 1'b1, 6, 4, 1'b1, 32'h0);
      xfer("after", 2'b10, 1'b1, 1'b0, 8'h10, 32'h0,         4'h0, 0, 1'b0, 4, 1, 1'b0, 32'hA5A5_1234);

      stuck = 1'b1;
      req_write[0] = 1'b1; req_addr[7:0] = 8'h40; req_wdata[31:0] = 32'h55; req_strb[3:0] = 4'hF;
      req_valid = 2'b01;
      #1;
      chk("rst_acc_ready", req_ready, 2'b01);
      @(posedge PCLK); #1;
      req_valid = 2'b00;
      @(posedge PCLK); #1;
      chk("rst_acc_in", {PSEL, PENABLE}, 2'b11);
      #2 PRESETn = 1'b0;
      #1;
      chk("rst_async", {PSEL, PENABLE, req_ready, rsp_valid, rsp_err, rsp_rdata}, 0);
      #2 PRESETn = 1'b1;
      stuck = 1'b0;
      @(posedge PCLK); #1;
      chk("rst_norsp1", {rsp_valid, PSEL}, 0);
      @(posedge PCLK); #1;
      chk("rst_norsp2", {rsp_valid, PSEL}, 0);

      req_write[1] = 1'b1; req_addr[15:8] = 8'h24; req_wdata[63:32] = 32'h3333_4444; req_strb[7:4] = 4'hF;
      xfer("rr0", 2'b11, 1'b0, 1'b1, 8'h20, 32'h1111_2222, 4'h3, 0, 1'b0, 3, 1, 1'b0, 32'h0);
      xfer("rr1", 2'b11, 1'b1, 1'b1, 8'h24, 32'h3333_4444, 4'hF, 0, 1'b0, 3, 1, 1'b0, 32'h0);
      xfer("rr2", 2'b11, 1'b0, 1'b0, 8'h20, 32'h0,         4'h0, 0, 1'b0, 4, 1, 1'b0, 32'h0000_2222);
      xfer("rr3", 2'b11, 1'b1, 1'b0, 8'h24, 32'h0,         4'h0, 0, 1'b0, 4, 1, 1'b0, 32'h3333_4444);

      req_valid = 2'b00;
      @(posedge PCLK); #1;
      chk("end_idle", {PSEL, PENABLE, rsp_valid, req_ready}, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
